// File: rtl/plic_pkg.sv
// Shared constants and register decode for the PLIC controller.
package plic_pkg;

   localparam int DEF_NUM_SRC = 8;
   localparam int DEF_PRIO_W  = 3;

   localparam logic [7:0] ADDR_PENDING   = 8'h80;
   localparam logic [7:0] ADDR_ENABLE    = 8'h84;
   localparam logic [7:0] ADDR_MODE      = 8'h88;
   localparam logic [7:0] ADDR_THRESHOLD = 8'h8C;
   localparam logic [7:0] ADDR_CLAIM     = 8'h90;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_PRIO,
      SEL_PEND,
      SEL_EN,
      SEL_MODE,
      SEL_THR,
      SEL_CLAIM
   } reg_sel_e;

   // Map a byte address onto a register class; the two low address bits
   // are dropped so any byte lane of a word selects that word.
   function automatic reg_sel_e decode_addr(input logic [7:0] addr, input int num_src);
      logic [7:0] a;
      int         word;
      reg_sel_e   sel;
      a    = addr & 8'hFC;
      word = int'(a[7:2]);
      sel  = SEL_NONE;
      if (a == ADDR_PENDING)
         sel = SEL_PEND;
      else if (a == ADDR_ENABLE)
         sel = SEL_EN;
      else if (a == ADDR_MODE)
         sel = SEL_MODE;
      else if (a == ADDR_THRESHOLD)
         sel = SEL_THR;
      else if (a == ADDR_CLAIM)
         sel = SEL_CLAIM;
      else if (word >= 1 && word <= num_src)
         sel = SEL_PRIO;
      return sel;
   endfunction

endpackage

// File: rtl/plic_ctrl_if.sv
// Register bus between a hart-side master and the PLIC controller.
interface plic_ctrl_if;

   logic        reg_we;
   logic        reg_re;
   logic [7:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic [31:0] reg_rdata;

   modport master (
      output reg_we,
      output reg_re,
      output reg_addr,
      output reg_wdata,
      input  reg_rdata
   );

   modport slave (
      input  reg_we,
      input  reg_re,
      input  reg_addr,
      input  reg_wdata,
      output reg_rdata
   );

endinterface

// File: rtl/plic_gateway.sv
// Per-source gateway: synchroniser, edge/level detection, pending and
// in-service tracking.  A claim always beats a same-cycle pending set.
module plic_gateway (
   input  logic clk,
   input  logic rst_n,
   input  logic i_src,
   input  logic i_mode,
   input  logic i_claim,
   input  logic i_complete,
   output logic o_pending,
   output logic o_in_service
);

   logic r_sync1;
   logic r_sync2;
   logic r_prev;
   logic r_pending;
   logic r_in_service;
   logic w_set;

   // Edge mode fires on a synchronised rise, level mode while high; nothing
   // is latched while the source is in service, so edges then are lost.
   assign w_set = ~r_in_service & (i_mode ? (r_sync2 & ~r_prev) : r_sync2);

   // Synchroniser chain plus pending/in-service state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1      <= 1'b0;
         r_sync2      <= 1'b0;
         r_prev       <= 1'b0;
         r_pending    <= 1'b0;
         r_in_service <= 1'b0;
      end else begin
         r_sync1 <= i_src;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         if (i_claim) begin
            r_pending    <= 1'b0;
            r_in_service <= 1'b1;
         end else begin
            if (w_set)
               r_pending <= 1'b1;
            if (i_complete)
               r_in_service <= 1'b0;
         end
      end
   end

   assign o_pending    = r_pending;
   assign o_in_service = r_in_service;

endmodule

// File: rtl/plic_ctrl.sv
// PLIC controller: register file, per-source gateways and arbitration
// producing a single registered interrupt line for one hart.
module plic_ctrl
   import plic_pkg::*;
#(
   parameter int NUM_SRC = DEF_NUM_SRC,
   parameter int PRIO_W  = DEF_PRIO_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_SRC-1:0] irq_src,
   plic_ctrl_if.slave         bus,
   output logic               irq_o
);

   localparam int ID_W = $clog2(NUM_SRC + 1);

   logic [PRIO_W-1:0]  r_prio [NUM_SRC];
   logic [NUM_SRC-1:0] r_enable;
   logic [NUM_SRC-1:0] r_mode;
   logic [PRIO_W-1:0]  r_thr;
   logic [31:0]        r_rdata;
   logic               r_irq;

   logic [NUM_SRC-1:0] w_pending;
   logic [NUM_SRC-1:0] w_in_service;
   logic [NUM_SRC-1:0] w_claim;
   logic [NUM_SRC-1:0] w_complete;
   logic [ID_W-1:0]    w_win_id;
   logic [PRIO_W-1:0]  w_win_prio;
   logic               w_irq;
   logic [ID_W-1:0]    w_claim_id;
   logic               w_claim_rd;
   logic               w_complete_wr;
   logic [5:0]         w_idx;
   reg_sel_e           w_sel;
   logic [31:0]        w_rd_val;

   assign w_sel         = decode_addr(bus.reg_addr, NUM_SRC);
   assign w_idx         = bus.reg_addr[7:2];
   assign w_claim_rd    = bus.reg_re & (w_sel == SEL_CLAIM);
   assign w_complete_wr = bus.reg_we & (w_sel == SEL_CLAIM);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
         // Only the source the claim actually returns is handed over.
         assign w_claim[gi]    = w_claim_rd & (w_claim_id == ID_W'(gi + 1));
         // Completes naming an idle source are dropped here.
         assign w_complete[gi] = w_complete_wr & (bus.reg_wdata == 32'(gi + 1))
                                 & w_in_service[gi];

         plic_gateway u_gateway (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_src        (irq_src[gi]),
            .i_mode       (r_mode[gi]),
            .i_claim      (w_claim[gi]),
            .i_complete   (w_complete[gi]),
            .o_pending    (w_pending[gi]),
            .o_in_service (w_in_service[gi])
         );

         // Priority register of this source.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               r_prio[gi] <= '0;
            else if (bus.reg_we && w_sel == SEL_PRIO && w_idx == 6'(gi + 1))
               r_prio[gi] <= bus.reg_wdata[PRIO_W-1:0];
         end
      end
   endgenerate

   // Shared control registers: enable, mode, threshold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_enable <= '0;
         r_mode   <= '0;
         r_thr    <= '0;
      end else if (bus.reg_we) begin
         case (w_sel)
            SEL_EN:   r_enable <= bus.reg_wdata[NUM_SRC:1];
            SEL_MODE: r_mode   <= bus.reg_wdata[NUM_SRC:1];
            SEL_THR:  r_thr    <= bus.reg_wdata[PRIO_W-1:0];
            default:  ;
         endcase
      end
   end

   // Winner search: strictly-greater replace keeps the lowest ID on ties,
   // and starting from zero excludes priority-0 sources.
   always_comb begin
      w_win_id   = '0;
      w_win_prio = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (w_pending[i] && r_enable[i] && (r_prio[i] > w_win_prio)) begin
            w_win_id   = ID_W'(i + 1);
            w_win_prio = r_prio[i];
         end
      end
   end

   assign w_irq      = (w_win_id != '0) && (w_win_prio > r_thr);
   assign w_claim_id = w_irq ? w_win_id : '0;

   // Read mux; all values come from pre-edge state so a same-cycle write
   // is not visible in the data returned.
   always_comb begin
      w_rd_val = '0;
      case (w_sel)
         SEL_PRIO: begin
            for (int i = 0; i < NUM_SRC; i++) begin
               if (w_idx == 6'(i + 1))
                  w_rd_val[PRIO_W-1:0] = r_prio[i];
            end
         end
         SEL_PEND:  w_rd_val[NUM_SRC:0] = {w_pending, 1'b0};
         SEL_EN:    w_rd_val[NUM_SRC:0] = {r_enable, 1'b0};
         SEL_MODE:  w_rd_val[NUM_SRC:0] = {r_mode, 1'b0};
         SEL_THR:   w_rd_val[PRIO_W-1:0] = r_thr;
         SEL_CLAIM: w_rd_val[ID_W-1:0] = w_claim_id;
         default:   w_rd_val = '0;
      endcase
   end

   // Registered read data (held between reads) and interrupt output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata <= '0;
         r_irq   <= 1'b0;
      end else begin
         r_irq <= w_irq;
         if (bus.reg_re)
            r_rdata <= w_rd_val;
      end
   end

   assign bus.reg_rdata = r_rdata;
   assign irq_o         = r_irq;

endmodule

// File: tb/tb_plic_ctrl.sv
// Bench for plic_ctrl: directed scenarios plus random traffic, every cycle
// checked against a rule-level model of the register map and gateways.
module tb_plic_ctrl;

   localparam int N  = 8;
   localparam int PW = 3;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] irq_src;
   logic         irq_o;

   plic_ctrl_if bus_if ();

   plic_ctrl #(.NUM_SRC(N), .PRIO_W(PW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .irq_src (irq_src),
      .bus     (bus_if.slave),
      .irq_o   (irq_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Model state, indexed by source ID.
   int           m_prio  [1:N];
   bit           m_pend  [1:N];
   bit           m_en    [1:N];
   bit           m_mode  [1:N];
   bit           m_insvc [1:N];
   int           m_thr;
   bit           m_irq;
   logic [31:0]  m_rdata;
   logic [N-1:0] hist [$];   // irq_src samples at previous edges, newest first

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 1; i <= N; i++) begin
         m_prio[i] = 0; m_pend[i] = 0; m_en[i] = 0; m_mode[i] = 0; m_insvc[i] = 0;
      end
      m_thr   = 0;
      m_irq   = 0;
      m_rdata = '0;
      hist    = {N'(0), N'(0), N'(0)};
   endtask

   function automatic logic [31:0] model_read(input logic [7:0] addr, input int cid);
      logic [7:0]  a;
      logic [31:0] v;
      int          w;
      a = addr & 8'hFC;
      w = int'(a) / 4;
      v = '0;
      if (a == 8'h80)      for (int i = 1; i <= N; i++) v[i] = m_pend[i];
      else if (a == 8'h84) for (int i = 1; i <= N; i++) v[i] = m_en[i];
      else if (a == 8'h88) for (int i = 1; i <= N; i++) v[i] = m_mode[i];
      else if (a == 8'h8C) v = 32'(m_thr);
      else if (a == 8'h90) v = 32'(cid);
      else if (w >= 1 && w <= N) v = 32'(m_prio[w]);
      return v;
   endfunction

   // Apply the rules for one rising edge, using the state before the edge.
   task automatic model_edge();
      int         best, win, cid, claimed, comp, w;
      bit         found, irq, lvl, edg, set;
      logic [7:0] a;
      a = bus_if.reg_addr & 8'hFC;
      best = 0;
      for (int i = 1; i <= N; i++)
         if (m_pend[i] && m_en[i] && m_prio[i] > best) best = m_prio[i];
      win = 0; found = 0;
      if (best > 0)
         for (int i = 1; i <= N; i++)
            if (!found && m_pend[i] && m_en[i] && m_prio[i] == best) begin
               win = i; found = 1;
            end
      irq = (win != 0) && (best > m_thr);
      cid = irq ? win : 0;
      if (bus_if.reg_re) m_rdata = model_read(bus_if.reg_addr, cid);
      claimed = (bus_if.reg_re && a == 8'h90) ? cid : 0;
      comp = (bus_if.reg_we && a == 8'h90 && bus_if.reg_wdata >= 1 && bus_if.reg_wdata <= N)
             ? int'(bus_if.reg_wdata) : 0;
      for (int i = 1; i <= N; i++) begin
         lvl = hist[1][i-1];
         edg = hist[1][i-1] && !hist[2][i-1];
         set = !m_insvc[i] && (m_mode[i] ? edg : lvl);
         if (claimed == i) begin
            m_pend[i] = 0; m_insvc[i] = 1;
         end else begin
            if (set) m_pend[i] = 1;
            if (comp == i && m_insvc[i]) m_insvc[i] = 0;
         end
      end
      if (bus_if.reg_we) begin
         w = int'(a) / 4;
         if (a == 8'h84)      for (int i = 1; i <= N; i++) m_en[i] = bus_if.reg_wdata[i];
         else if (a == 8'h88) for (int i = 1; i <= N; i++) m_mode[i] = bus_if.reg_wdata[i];
         else if (a == 8'h8C) m_thr = int'(bus_if.reg_wdata) & ((1 << PW) - 1);
         else if (a != 8'h80 && a != 8'h90 && w >= 1 && w <= N)
            m_prio[w] = int'(bus_if.reg_wdata) & ((1 << PW) - 1);
      end
      m_irq = irq;
      hist.push_front(irq_src);
      void'(hist.pop_back());
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("irq_o", 32'(irq_o), 32'(m_irq));
      chk("rdata", bus_if.reg_rdata, m_rdata);
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      bus_if.reg_we = 1'b1; bus_if.reg_addr = a; bus_if.reg_wdata = d;
      step();
      bus_if.reg_we = 1'b0;
      $display("wr addr=%02h data=%08h", a, d);
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] d);
      bus_if.reg_re = 1'b1; bus_if.reg_addr = a;
      step();
      bus_if.reg_re = 1'b0;
      d = bus_if.reg_rdata;
      $display("rd addr=%02h data=%08h", a, d);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst_irq", 32'(irq_o), 32'h0);
      chk("rst_rdata", bus_if.reg_rdata, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      $display("reset pulse done");
   endtask

   logic [31:0] d;

   initial begin
      rst_n = 1'b1;
      irq_src = '0;
      bus_if.reg_we = 1'b0; bus_if.reg_re = 1'b0;
      bus_if.reg_addr = '0; bus_if.reg_wdata = '0;
      model_reset();
      #2;

      // Edge, single source: ID 3, 4-edge latency
      do_reset();
      wr(8'h0C, 2); wr(8'h84, 32'h08); wr(8'h88, 32'h08); wr(8'h8C, 0);
      irq_src[2] = 1'b1; step(); irq_src[2] = 1'b0;
      idle(2);
      chk("t1_irq_edge3", 32'(irq_o), 0);
      step();
      chk("t1_irq_edge4", 32'(irq_o), 1);
      rd(8'h90, d); chk("t1_claim", d, 3);
      rd(8'h80, d); chk("t1_pend_after_claim", d, 0);
      wr(8'h90, 3);

      // Priority order and tie break
      do_reset();
      wr(8'h08, 4); wr(8'h14, 4); wr(8'h1C, 6);
      wr(8'h84, 32'hA4); wr(8'h88, 32'hA4); wr(8'h8C, 0);
      irq_src = 8'b0101_0010; step(); irq_src = '0;
      idle(4);
      rd(8'h90, d); chk("t2_claim_a", d, 7); wr(8'h90, 7);
      rd(8'h90, d); chk("t2_claim_b", d, 2); wr(8'h90, 2);
      rd(8'h90, d); chk("t2_claim_c", d, 5); wr(8'h90, 5);
      rd(8'h90, d); chk("t2_claim_none", d, 0);

      // Threshold gating
      do_reset();
      wr(8'h04, 3); wr(8'h84, 32'h02); wr(8'h8C, 3);
      irq_src[0] = 1'b1;
      idle(6);
      chk("t3_irq_at_thr", 32'(irq_o), 0);
      wr(8'h8C, 2);
      step();
      chk("t3_irq_below_thr", 32'(irq_o), 1);
      rd(8'h90, d); chk("t3_claim", d, 1);
      irq_src[0] = 1'b0;
      idle(4);
      wr(8'h90, 1);

      // Level re-arm, then edges discarded during service
      do_reset();
      wr(8'h10, 1); wr(8'h84, 32'h10);
      irq_src[3] = 1'b1;
      idle(5);
      rd(8'h90, d); chk("t4_claim_lvl", d, 4);
      rd(8'h80, d); chk("t4_pend_in_svc", d, 0);
      wr(8'h90, 4);
      step();
      rd(8'h80, d); chk("t4_pend_rearm", d, 32'h10);
      wr(8'h88, 32'h10);
      rd(8'h80, d); chk("t4_pend_mode_chg", d, 32'h10);
      rd(8'h90, d); chk("t4_claim_edge", d, 4);
      irq_src[3] = 1'b0; idle(3);
      irq_src[3] = 1'b1; idle(4);
      wr(8'h90, 4);
      idle(4);
      rd(8'h80, d); chk("t4_pend_no_second", d, 0);
      irq_src = '0;

      // Boundaries: bad complete, empty claim, unmapped space, reset mid-claim
      do_reset();
      wr(8'h90, 9);
      rd(8'h90, d); chk("t5_claim_empty", d, 0);
      wr(8'h00, 7);
      rd(8'h00, d); chk("t5_unmapped_00", d, 0);
      rd(8'hFC, d); chk("t5_unmapped_fc", d, 0);
      wr(8'h0D, 32'hF);
      rd(8'h0C, d); chk("t5_prio_width", d, 7);
      wr(8'h84, 32'h08); wr(8'h88, 32'h08);
      irq_src[2] = 1'b1; step(); irq_src[2] = 1'b0;
      idle(4);
      rd(8'h90, d); chk("t5_claim", d, 3);
      wr(8'h90, 9);
      rd(8'h80, d); chk("t5_pend_after_bad_complete", d, 0);
      do_reset();
      for (int i = 1; i <= N; i++) begin
         rd(8'(4 * i), d); chk("t5_prio_after_rst", d, 0);
      end
      rd(8'h80, d); chk("t5_pend_after_rst", d, 0);
      rd(8'h84, d); chk("t5_en_after_rst", d, 0);
      rd(8'h88, d); chk("t5_mode_after_rst", d, 0);
      rd(8'h8C, d); chk("t5_thr_after_rst", d, 0);
      wr(8'h0C, 1); wr(8'h84, 32'h08); wr(8'h88, 32'h08);
      irq_src[2] = 1'b1; step(); irq_src[2] = 1'b0;
      idle(4);
      rd(8'h90, d); chk("t5_claim_after_rst", d, 3);
      wr(8'h90, 3);

      // Random traffic against the model
      do_reset();
      for (int k = 0; k < 500; k++) begin
         int r;
         if ($urandom_range(0, 3) == 0)
            irq_src = irq_src ^ N'(1 << $urandom_range(0, N - 1));
         bus_if.reg_we = ($urandom_range(0, 2) == 0);
         bus_if.reg_re = ($urandom_range(0, 2) == 0);
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2: bus_if.reg_addr = 8'(4 * $urandom_range(0, N + 1) + $urandom_range(0, 3));
            3:       bus_if.reg_addr = 8'h80;
            4:       bus_if.reg_addr = 8'h84;
            5:       bus_if.reg_addr = 8'h88;
            6:       bus_if.reg_addr = 8'h8C;
            7, 8:    bus_if.reg_addr = 8'h90;
            default: bus_if.reg_addr = 8'($urandom_range(0, 255));
         endcase
         bus_if.reg_wdata = $urandom;
         if ((bus_if.reg_addr & 8'hFC) == 8'h90) bus_if.reg_wdata = $urandom_range(0, 10);
         if ((bus_if.reg_addr & 8'hFC) == 8'h8C) bus_if.reg_wdata = $urandom_range(0, 2);
         step();
         if (bus_if.reg_we || bus_if.reg_re)
            $display("rnd we=%0b re=%0b addr=%02h wdata=%08h rdata=%08h irq=%0b",
                     bus_if.reg_we, bus_if.reg_re, bus_if.reg_addr, bus_if.reg_wdata,
                     bus_if.reg_rdata, irq_o);
      end
      bus_if.reg_we = 1'b0; bus_if.reg_re = 1'b0;
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/plic_ctrl.md
PLIC_CTRL -- requirements
Module: plic_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 8, meaning number of interrupt sources (1..31); source IDs are 1..NUM_SRC, and ID 0 means "no interrupt".
REQ-002 SHALL have parameter PRIO_W, default 3, meaning priority field width.
REQ-003 SHALL have derived localparam ID_W = $clog2(NUM_SRC+1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port irq_src, input, NUM_SRC bits: raw asynchronous source lines; bit i-1 is ID i.
REQ-007 SHALL have port reg_we, input, 1 bit: register write strobe.
REQ-008 SHALL have port reg_re, input, 1 bit: register read strobe.
REQ-009 SHALL have port reg_addr, input, 8 bits: byte address; bits [1:0] are ignored.
REQ-010 SHALL have port reg_wdata, input, 32 bits: write data.
REQ-011 SHALL have port reg_rdata, output, 32 bits: read data, registered.
REQ-012 SHALL have port irq_o, output, 1 bit: interrupt request to the hart, registered.

Function
REQ-013 SHALL implement this register map:
- priority[i] at 4*i, i=1..NUM_SRC, RW, PRIO_W bits
- pending at 0x80, RO, bit i = ID i
- enable at 0x84, RW
- mode at 0x88, RW (1 = edge, 0 = level)
- threshold at 0x8C, RW
- claim/complete at 0x90
REQ-014 SHALL return zero on reads of unmapped addresses and of unimplemented bits, and SHALL ignore writes to them.
REQ-015 SHALL present reg_rdata one cycle after reg_re is sampled high; reg_rdata holds its value otherwise.
REQ-016 SHALL pass each irq_src bit through a two-flop synchroniser before any use.
REQ-017 In edge mode, SHALL set pending on a synchronised 0->1 transition.
REQ-018 In level mode, SHALL set pending while the synchronised level is 1.
REQ-019 SHALL never set pending for a source that is in service (claimed, not completed); edges arriving in service are discarded.
REQ-020 SHALL select the winner as the pending, enabled source with priority > 0 and the highest priority; ties go to the lowest ID; no candidate means winner ID 0.
REQ-021 SHALL drive irq_o = 1 when winner ID != 0 and winner priority > threshold, registered.
REQ-022 Latency: an irq_src edge at cycle 0 with everything else enabled SHALL produce irq_o = 1 at the 4th rising edge.
REQ-023 A claim read of 0x90 SHALL return the current winner ID (0 if irq_o would be 0).
REQ-024 A claim read with a non-zero ID SHALL, on the same edge, clear that pending bit and set in_service.
REQ-025 A claim read returning 0 SHALL change no state.
REQ-026 A write of ID k to 0x90 (complete) SHALL clear in_service[k]; if k is not in service or k > NUM_SRC, the write SHALL be ignored.
REQ-027 For a level source still high after completion, SHALL set pending again on the next edge.
REQ-028 When a claim and a pending-set for the same source fall in the same cycle, the claim SHALL win (pending = 0, in_service = 1).
REQ-029 When reg_we and reg_re are both high in one cycle, both SHALL take effect; the read returns pre-write data.
REQ-030 Changing mode on a source SHALL NOT clear its pending bit.

Reset
REQ-031 While rst_n = 0, SHALL reset priority, pending, enable, mode, threshold, in_service and synchroniser flops to 0, and drive irq_o = 0 and reg_rdata = 0.
REQ-032 Reset asserted mid-claim SHALL discard all in-service state; after release, no source SHALL be in service.

Structure
REQ-033 SHALL place the address offsets (0x80..0x90) and the default NUM_SRC/PRIO_W values in a shared package plic_pkg.
REQ-034 SHALL instantiate one sub-module, plic_gateway, per source; it contains the synchroniser, edge/level detect, pending and in_service flops.
REQ-035 SHALL keep arbitration and the register file in plic_ctrl.

Verification
REQ-036 Edge, single source: ID 3, prio 2, thr 0, enabled, edge mode, pulse irq_src[2] -> irq_o = 1 at cycle 4; claim returns 3; pending = 0.
REQ-037 Tie and priority: IDs 2 and 5 at prio 4, ID 7 at prio 6, all pending -> claims return 7, then 2, then 5, with completes in between.
REQ-038 Threshold: ID 1 prio 3, thr 3 -> irq_o stays 0; write thr 2 -> irq_o = 1 within 1 cycle.
REQ-039 Level re-arm: ID 4 level mode held high, claim 4, complete 4 -> pending[4] = 1 again one edge later; edges during service give no second pending in edge mode.
REQ-040 Boundaries: complete 9 with NUM_SRC = 8 -> no change; claim with nothing pending -> 0; rst_n pulse after a claim -> all registers 0, in_service cleared.
